matrix_entry_loader: RTL
========================

// Module: matrix_entry_loader
// PURPOSE
//  Front-end for the systolic array: loads two 2x2 8-bit operands, A then B, from the board switches.
//  Each value is committed by pressing the enter button. After the 8th value it pulses start to the array,
//  then waits for sa_done. entry_idx and preview feed display_module so the user sees what is being entered.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  cycles a synchronized button must hold a new level before it is accepted (10 ms @100 MHz)
// PORTS
//  clock_100Mhz  in   1  system clock; all logic on rising edge
//  reset         in   1  synchronous, active-high
//  sw            in   8  operand value from switches (quasi-static, sampled directly)
//  btn_enter     in   1  raw enter push-button, asynchronous, bouncing
//  btn_clear     in   1  raw clear push-button, asynchronous, bouncing
//  sa_done       in   1  array finished; single-cycle or level, sampled only in RUN
//  a11,a12,a21,a22 out 8 matrix A operand registers
//  b11,b12,b21,b22 out 8 matrix B operand registers
//  entry_idx     out  3  next slot to fill: 0..3 = a11,a12,a21,a22; 4..7 = b11,b12,b21,b22
//  preview       out  8  registered copy of sw, 1-cycle delay, for display
//  state         out  2  0=ENTRY 1=START 2=RUN 3=HOLD
//  start         out  1  one-cycle pulse to the array
// BEHAVIOUR
//  Reset: all 8 operands=0, entry_idx=0, preview=0, state=ENTRY, start=0; debouncers idle, debounced level=0.
//  Button path, per button:
//   - 2-flop synchronizer.
//   - Debounce counter clears when sync output == debounced level. Otherwise it increments.
//   - Debounced level toggles in the cycle the counter reaches DEBOUNCE_CYCLES-1; counter clears then.
//   - Press pulse (1 cycle) fires the cycle after debounced 0->1. Release produces no pulse.
//  ENTRY: enter pulse writes sw into slot entry_idx; entry_idx++.
//   - Writing slot 7 sets entry_idx=0 and goes to START.
//   - Clear pulse sets entry_idx=0; operand values are kept.
//   - Enter and clear pulse in same cycle: clear wins, nothing is written.
//  START: start=1 for exactly this one cycle; unconditionally goes to RUN.
//  RUN: operands frozen; enter/clear pulses ignored.
//   - sa_done=1 -> HOLD. Stays in RUN indefinitely otherwise.
//  HOLD: operands retained for display.
//   - Enter pulse -> ENTRY with entry_idx=0 (that press writes nothing).
//   - Clear pulse -> ENTRY with entry_idx=0.
//  sa_done outside RUN: ignored.
//  reset in any state (including RUN mid-computation): immediate return to reset values next edge; start never glitches.
//  Operand writes only in ENTRY; operands change at most one per cycle.
// TESTING  (DEBOUNCE_CYCLES=4 in bench)
//  Bounce: btn_enter toggles every 2 cycles for 10 cycles, then held high with sw=8'h05.
//   -> exactly one write, a11=05, entry_idx=1.
//  Full load: presses with sw=1..8.
//   -> a11..a22=1,2,3,4; b11..b22=5,6,7,8; state ENTRY->START->RUN; start high exactly 1 cycle.
//   -> entry_idx=0.
//  RUN lockout: 3 enter presses in RUN -> operands unchanged.
//   -> sa_done pulse -> state=HOLD.
//   -> next enter press -> ENTRY, idx=0, a11 still 1.
//  Clear: enter x3 (sw=9), then clear.
//   -> entry_idx=0, a11..a21=9.
//   -> next press with sw=2 overwrites a11=2.
//  Simultaneous: enter and clear debounced-rise same cycle at idx=2 -> idx=0, no write.
//  Reset mid-RUN: reset 1 cycle -> operands 0, state ENTRY, start=0; a stray sa_done afterward has no effect.

Source files
------------

// File: rtl/matrix_entry_loader.sv
// matrix_entry_loader: debounced button front-end that loads two 2x2 8-bit operands and starts the systolic array
// Ports: clock_100Mhz/reset (sync, active-high); sw operand value; btn_enter/btn_clear raw buttons;
//        sa_done array finished; a11..b22 operand registers; entry_idx next slot; preview registered sw;
//        state 0=ENTRY 1=START 2=RUN 3=HOLD; start one-cycle array pulse
module matrix_entry_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic       sa_done,
  output logic [7:0] a11,
  output logic [7:0] a12,
  output logic [7:0] a21,
  output logic [7:0] a22,
  output logic [7:0] b11,
  output logic [7:0] b12,
  output logic [7:0] b21,
  output logic [7:0] b22,
  output logic [2:0] entry_idx,
  output logic [7:0] preview,
  output logic [1:0] state,
  output logic       start
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {ENTRY = 2'd0, START = 2'd1, RUN = 2'd2, HOLD = 2'd3} state_t;
  logic [1:0]    r_s1, r_s2, r_db, r_db_d;
  logic [CW-1:0] r_cnt [2];
  logic [7:0]    r_op [8];
  logic [2:0]    r_idx;
  logic [7:0]    r_preview;
  state_t        r_state;
  logic          r_start;
  logic [1:0]    w_btn, w_press;
  logic          w_enter, w_clear;
  assign w_btn   = {btn_clear, btn_enter};
  // one-cycle pulse in the cycle after the debounced level rises; releases are ignored
  assign w_press = r_db & ~r_db_d;
  assign w_enter = w_press[0];
  assign w_clear = w_press[1];
  // bit 0 = enter, bit 1 = clear; counter only runs while the synced input disagrees with the debounced level
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_db   <= '0;
      r_db_d <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_s1   <= w_btn;
      r_s2   <= r_s1;
      r_db_d <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_db[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_cnt[i] <= '0;
          r_db[i]  <= ~r_db[i];
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end
  // start is registered and asserted exactly while the state register holds START
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_op[i] <= '0;
      r_idx     <= '0;
      r_preview <= '0;
      r_state   <= ENTRY;
      r_start   <= 1'b0;
    end else begin
      r_preview <= sw;
      case (r_state)
        ENTRY: begin
          if (w_clear) r_idx <= '0;
          else if (w_enter) begin
            r_op[r_idx] <= sw;
            r_idx       <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= START;
              r_start <= 1'b1;
            end
          end
        end
        START: begin
          r_state <= RUN;
          r_start <= 1'b0;
        end
        RUN: if (sa_done) r_state <= HOLD;
        HOLD: if (w_enter || w_clear) begin
          r_state <= ENTRY;
          r_idx   <= '0;
        end
        default: r_state <= ENTRY;
      endcase
    end
  end
  assign a11       = r_op[0];
  assign a12       = r_op[1];
  assign a21       = r_op[2];
  assign a22       = r_op[3];
  assign b11       = r_op[4];
  assign b12       = r_op[5];
  assign b21       = r_op[6];
  assign b22       = r_op[7];
  assign entry_idx = r_idx;
  assign preview   = r_preview;
  assign state     = r_state;
  assign start     = r_start;
endmodule
